// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the Moore sequence detector.
// One skid word in `hold` backs up the shift register so that consecutive
// words leave on seq_out with no idle bit between them.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | shift register empty, seq_out parked low, waiting for hold
// SHIFT | a word is on seq_out, cnt indexes the bit being presented
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             accept;

  // Accept and reload are mutually exclusive because ready is just !hold_full.
  assign accept = din_valid && din_ready;

  // Skid register, shift register, bit counter and state in one process so
  // the hold_full set (accept) and clear (reload) share a single driver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (hold_full) begin
              sh        <= hold;
              hold_full <= 1'b0;
              cnt       <= '0;
              state     <= SHIFT;
            end
          end
          default: begin
            if (cnt == LAST) begin
              if (hold_full) begin
                sh        <= hold;
                hold_full <= 1'b0;
                cnt       <= '0;
              end else begin
                sh    <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              if (MSB_FIRST) begin
                sh <= {sh[WIDTH-2:0], 1'b0};
              end else begin
                sh <= {1'b0, sh[WIDTH-1:1]};
              end
              cnt <= cnt + CW'(1);
            end
          end
        endcase
      end
    end
  end

  // Outputs decode registered state only; no path from din_valid to din_ready.
  always_comb begin
    din_ready   = !hold_full;
    seq_valid   = (state == SHIFT);
    seq_out     = seq_valid && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
    frame_start = seq_valid && (cnt == '0);
    frame_last  = seq_valid && (cnt == LAST);
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: an MSB-first and an LSB-first instance.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       bit_en = 1'b0;
  logic       seq_out, seq_valid, frame_start, frame_last;

  logic [7:0] l_din = '0;
  logic       l_valid = 1'b0;
  logic       l_ready;
  logic       l_bit_en = 1'b0;
  logic       l_out, l_seq_valid, l_start, l_last;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] w;
  logic [7:0]  b;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bit_en(bit_en), .seq_out(seq_out),
    .seq_valid(seq_valid), .frame_start(frame_start), .frame_last(frame_last)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .bit_en(l_bit_en), .seq_out(l_out),
    .seq_valid(l_seq_valid), .frame_start(l_start), .frame_last(l_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset asserted with no clock edge
    #2 reset = 1'b0;
    #2;
    check("rst_seq_out", seq_out, 0);
    check("rst_seq_valid", seq_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_last", frame_last, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_lsb_ready", l_ready, 1);
    step();
    reset = 1'b1;

    // single word 8'hB0, MSB first
    bit_en = 1'b1;
    din = 8'hB0; din_valid = 1'b1;
    step();
    check("single_accept_ready", din_ready, 0);
    check("single_idle_after_e0", seq_valid, 0);
    din_valid = 1'b0;
    step();
    b = 8'hB0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single_bit%0d", i), seq_out, b[7-i]);
      check($sformatf("single_valid%0d", i), seq_valid, 1);
      check($sformatf("single_start%0d", i), frame_start, (i == 0) ? 1 : 0);
      check($sformatf("single_last%0d", i), frame_last, (i == 7) ? 1 : 0);
      step();
    end
    check("single_end_valid", seq_valid, 0);
    check("single_end_out", seq_out, 0);

    // back-to-back 8'hB0 then 8'h6C; 6C held while hold is full
    din = 8'hB0; din_valid = 1'b1;
    step();
    din = 8'h6C;
    step();
    check("b2b_ready_after_reload", din_ready, 1);
    w = 16'hB06C;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_bit%0d", i), seq_out, w[15-i]);
      check($sformatf("b2b_valid%0d", i), seq_valid, 1);
      check($sformatf("b2b_start%0d", i), frame_start, (i % 8 == 0) ? 1 : 0);
      check($sformatf("b2b_last%0d", i), frame_last, (i % 8 == 7) ? 1 : 0);
      step();
      if (i == 0) begin
        check("b2b_second_accepted", din_ready, 0);
        din_valid = 1'b0;
      end
    end
    check("b2b_end_valid", seq_valid, 0);

    // enable stall: each bit held two cycles, word accepted mid-stall
    din = 8'hA5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    w = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stall_bit%0d", i), seq_out, w[15-i]);
      check($sformatf("stall_start%0d", i), frame_start, (i % 8 == 0) ? 1 : 0);
      check($sformatf("stall_last%0d", i), frame_last, (i % 8 == 7) ? 1 : 0);
      bit_en = 1'b0;
      if (i == 0) begin
        din = 8'h3C; din_valid = 1'b1;
      end
      step();
      if (i == 0) begin
        check("stall_accept_ready", din_ready, 0);
        din_valid = 1'b0;
      end
      check($sformatf("stall_hold_bit%0d", i), seq_out, w[15-i]);
      check($sformatf("stall_hold_start%0d", i), frame_start, (i % 8 == 0) ? 1 : 0);
      check($sformatf("stall_hold_valid%0d", i), seq_valid, 1);
      bit_en = 1'b1;
      step();
    end
    check("stall_end_valid", seq_valid, 0);

    // LSB-first instance, 8'h0D -> 1,0,1,1,0,0,0,0
    l_bit_en = 1'b1;
    l_din = 8'h0D; l_valid = 1'b1;
    step();
    l_valid = 1'b0;
    step();
    b = 8'hB0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_bit%0d", i), l_out, b[7-i]);
      check($sformatf("lsb_start%0d", i), l_start, (i == 0) ? 1 : 0);
      check($sformatf("lsb_last%0d", i), l_last, (i == 7) ? 1 : 0);
      step();
    end
    check("lsb_end_valid", l_seq_valid, 0);

    // reset mid-frame with seq_out high and a word waiting in hold
    din = 8'hFF; din_valid = 1'b1;
    step();
    din = 8'h81;
    step();
    step();
    din_valid = 1'b0;
    check("midrst_pre_out", seq_out, 1);
    check("midrst_pre_ready", din_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_out", seq_out, 0);
    check("midrst_valid", seq_valid, 0);
    check("midrst_start", frame_start, 0);
    check("midrst_last", frame_last, 0);
    check("midrst_ready", din_ready, 1);
    step();
    #1 reset = 1'b1;
    step();
    step();
    step();
    check("midrst_no_replay", seq_valid, 0);
    check("midrst_ready_after", din_ready, 1);

    // first edge after release accepts normally
    reset = 1'b0;
    #1;
    din = 8'h80; din_valid = 1'b1;
    #1 reset = 1'b1;
    step();
    check("post_rst_accept", din_ready, 0);
    din_valid = 1'b0;
    step();
    check("post_rst_first_bit", seq_out, 1);
    check("post_rst_start", frame_start, 1);
    step();
    check("post_rst_second_bit", seq_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the Moore sequence detector. Accepts WIDTH-bit words over a valid/ready handshake, holds one word in a skid register, and shifts it out one bit per enabled clock on `seq_out`, which drives the detector's `seq_in` directly. Back-to-back words stream with no idle bit between them, so detections spanning word boundaries are preserved.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset asserted.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  serializer can accept a word; transfer occurs on an edge with `din_valid & din_ready`.
- `bit_en`  in  1  bit-rate enable; shifting and loading advance only on edges with `bit_en`=1.
- `seq_out`  out  1  serial bit to detector `seq_in`.
- `seq_valid`  out  1  `seq_out` carries a word bit.
- `frame_start`  out  1  high while the first bit of a word is on `seq_out`.
- `frame_last`  out  1  high while the last bit of a word is on `seq_out`.

## Operation
- Storage: holding register `hold` + flag `hold_full`; shift register `sh`; bit counter `cnt` (0..WIDTH-1); state IDLE or SHIFT.
- `din_ready` = !`hold_full`, decoded from registers only (no combinational path from `din_valid`).
- Accept: on edge with `din_valid & din_ready`, `hold` <= `din`, `hold_full` <= 1. `din_valid` with `din_ready`=0 is ignored; the source holds `din`.
- IDLE: on edge with `bit_en`=1 and `hold_full`=1: `sh` <= `hold`, `hold_full` <= 0, `cnt` <= 0, -> SHIFT.
- SHIFT, `bit_en`=1, `cnt` < WIDTH-1: `sh` shifts one place toward output (left if MSB_FIRST, else right, zero-fill), `cnt` += 1.
- SHIFT, `bit_en`=1, `cnt` = WIDTH-1: if `hold_full`, reload `sh` from `hold`, clear `hold_full`, `cnt` <= 0, stay SHIFT (no gap); else -> IDLE, `sh` <= 0.
- `bit_en`=0: `sh`, `cnt` and state frozen; accepts into `hold` still occur.
- `seq_out` = `sh[WIDTH-1]` (MSB_FIRST=1) or `sh[0]`; 0 in IDLE.
- `seq_valid` = (state == SHIFT). `frame_start` = SHIFT & `cnt`==0. `frame_last` = SHIFT & `cnt`==WIDTH-1.
- Accept and reload on the same edge cannot occur (`din_ready`=0 while `hold_full`); a word accepted any time before the last enabled bit edge of the current word streams back-to-back.

## Timing
- Reset values (immediate on `reset`=0, independent of `clk`): state IDLE, `sh`=0, `cnt`=0, `hold_full`=0; outputs `seq_out`=0, `seq_valid`=0, `frame_start`=0, `frame_last`=0, `din_ready`=1.
- Latency, `bit_en`=1 continuously, IDLE: word accepted at edge E0 -> `hold_full`=1 after E0 -> loaded at E1 -> first bit on `seq_out` after E1; last bit after E(WIDTH).
- Each bit stays on `seq_out` until the next edge with `bit_en`=1.
- Throughput: one bit per enabled cycle; sustained with one word accepted per WIDTH enabled cycles.
- Reset mid-word: current and held words discarded; no partial word replayed after release.
- First edge after reset release is a normal edge (accept permitted).

## Test plan
- Reset: `reset`=0 mid-frame with `seq_out`=1 -> all outputs return to reset values without a clock edge; `din_ready`=1 after release.
- Single word, MSB_FIRST=1, WIDTH=8, `din`=8'hB0, `bit_en`=1 -> after E1 `seq_out` = 1,0,1,1,0,0,0,0 on consecutive cycles; `frame_start` on bit 0, `frame_last` on bit 7; IDLE, `seq_valid`=0 after E9.
- Back-to-back: 8'hB0 then 8'h6C offered immediately -> 16 contiguous valid bits 1011_0000_0110_1100, no gap; `din_ready`=0 from accept until reload; detector downstream asserts det_out for each 1011.
- LSB-first: MSB_FIRST=0, `din`=8'h0D -> bits 1,0,1,1,0,0,0,0.
- Enable stall: `bit_en` toggled 1,0,1,0 -> each bit held two cycles; `cnt` and `seq_out` unchanged on `bit_en`=0 edges; a word accepted during a stall lands in `hold`.
- Backpressure: `din_valid` held with `hold_full`=1 -> no overwrite of `hold`; word accepted on the first edge after reload clears `hold_full`.
